ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
Sequencer that programs one configuration chain of sofa_plus ccff memories (e.g. the 2-bit MODE_SEL cells of the ff/LUT tiles).
- Accepts the bitstream as WORD_W-bit words over a valid/ready interface.
- Serializes each word LSB-first onto ccff_head.
- Gates config_enable so the chain advances exactly CHAIN_LEN times.
- Signals completion.
- Sits between the bitstream source (SPI/JTAG bridge) and the chain head of a tile column, in the prog_clk domain.

Parameters:
CHAIN_LEN, 64, number of ccff cells in the chain (≥1).
WORD_W, 8, bitstream word width (≥1).
CNT_W, 16, bit-counter width; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
prog_clk  in  1  programming clock; all state on rising edge.
pReset  in  1  synchronous, active-high reset.
start  in  1  one-cycle request to begin loading; sampled only in IDLE.
word_in  in  WORD_W  bitstream word; bit 0 is shifted first.
word_valid  in  1  word_in valid.
word_ready  out  1  loader can accept a word this cycle.
ccff_head  out  1  serial data to the chain head.
ccff_tail  in  1  serial data from the chain tail (used only with the optional feature).
config_enable  out  1  chain shift enable; the chain advances one cell on each prog_clk edge where this is 1.
busy  out  1  high in any state other than IDLE.
done  out  1  one-cycle pulse when loading (and the check, if compiled) completes.
bit_count  out  CNT_W  number of bits shifted into the chain so far.
err  out  1  readback mismatch flag (tied 0 without the optional feature).

Behaviour:
- Reset (pReset=1 at an edge, from any state):
  - Go to IDLE.
  - word_ready=0, config_enable=0, ccff_head=0, busy=0, done=0, bit_count=0, err=0.
  - Reset mid-load abandons the partial load; no further config_enable pulses occur.
- States: IDLE, FETCH, SHIFT, DONE (plus VERIFY with the optional feature).
- IDLE:
  - start=1 → FETCH; bit_count cleared to 0; err cleared.
  - start=0 → stay.
- FETCH:
  - word_ready=1, config_enable=0.
  - On word_valid & word_ready: latch word_in into the shift register; bits_left = min(WORD_W, CHAIN_LEN − bit_count); → SHIFT next cycle.
  - word_valid=0 → stay (stall); the chain holds its contents.
- SHIFT:
  - word_ready=0, config_enable=1, ccff_head = shreg[0].
  - Each cycle: shreg >>= 1, bit_count+1, bits_left−1.
  - When bits_left reaches 0:
    - bit_count == CHAIN_LEN → DONE.
    - Otherwise → FETCH.
  - Partial last word: excess upper bits are discarded and never shifted.
- Per-word latency: 1 accept cycle plus bits_left shift cycles.
  - Minimum full-chain load = ceil(CHAIN_LEN/WORD_W) + CHAIN_LEN cycles with word_valid held high.
- DONE:
  - done=1 for exactly one cycle; config_enable=0 → IDLE.
  - bit_count holds CHAIN_LEN until the next start.
- config_enable is never 1 outside SHIFT/VERIFY.
  - Total config_enable-high cycles per load = CHAIN_LEN (2·CHAIN_LEN with the optional feature).
- start while busy: ignored.
- word_valid while not in FETCH: ignored; no word is consumed.
- ccff_head outside SHIFT/VERIFY: 0.

Optional Feature:
Macro CCFF_LOADER_READBACK_CHECK_EN.
- When defined:
  - During SHIFT, the loader accumulates ones_ref = popcount of the bits shifted in.
  - After the last SHIFT cycle the FSM enters VERIFY instead of DONE.
  - VERIFY runs CHAIN_LEN cycles with config_enable=1 and ccff_head=ccff_tail (rotation), so the chain contents are restored.
  - During VERIFY the loader counts ones seen on ccff_tail into ones_rd.
  - On exit to DONE: err = (ones_rd != ones_ref); err holds until the next start or reset.
  - bit_count is not incremented in VERIFY.
- When undefined: no VERIFY state, no counters; err tied 0; ccff_tail unused.

Test Plan:
- Reset mid-load (CHAIN_LEN=20, WORD_W=8): assert pReset during SHIFT after 5 bits → next cycle all outputs 0, state IDLE; a following start/load completes normally.
- Full load (CHAIN_LEN=20, WORD_W=8): start, words 0xA5, 0x3C, 0xF7 with valid held → exactly 20 config_enable cycles; ccff_head sequence 1,0,1,0,0,1,0,1, 0,0,1,1,1,1,0,0, 1,1,1,0; 0xF7 upper nibble dropped; done pulses once; bit_count=20; chain model matches.
- Stall (CHAIN_LEN=20, WORD_W=8): word_valid low 7 cycles in FETCH after word 1 → config_enable stays 0 throughout the stall, bit_count=8 held, word_ready=1; load resumes correctly.
- Ignored inputs: start pulsed during SHIFT → no restart, bit_count unaffected; word_valid=1 during SHIFT → word_ready=0, word not consumed.
- Exact-multiple load (CHAIN_LEN=16, WORD_W=8): 2 words → 16 shifts, DONE directly after the second word; no third FETCH.
- Readback check (CCFF_LOADER_READBACK_CHECK_EN): correct chain model → err=0 and chain contents unchanged after VERIFY; force one tail bit flipped → err=1 after done.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// Loads a sofa_plus ccff configuration chain from a word stream, serializing LSB-first.
// Optional readback popcount check: define CCFF_LOADER_READBACK_CHECK_EN.
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 8,
  parameter int CNT_W     = 16
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  bit_count,
  output logic              err
);

  localparam int               WMIN   = (WORD_W < CHAIN_LEN) ? WORD_W : CHAIN_LEN;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] WORD_C = CNT_W'(WMIN);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

`ifdef CCFF_LOADER_READBACK_CHECK_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_VERIFY, S_DONE} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SHIFT, S_DONE} state_t;
`endif

  state_t            state_q;
  logic [WORD_W-1:0] shreg_q;
  logic [CNT_W-1:0]  bits_left_q;
  logic [CNT_W-1:0]  bit_count_q;
  logic              word_ready_q;
  logic              ce_q;
  logic              head_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  remain_d;
  logic [CNT_W-1:0]  take_d;
  logic [CNT_W-1:0]  bit_count_d;

  // A partial last word only takes what the chain still has room for.
  assign remain_d    = LEN_C - bit_count_q;
  assign take_d      = (remain_d < WORD_C) ? remain_d : WORD_C;
  assign bit_count_d = bit_count_q + ONE_C;

`ifdef CCFF_LOADER_READBACK_CHECK_EN
  logic [CNT_W-1:0] ones_ref_q;
  logic [CNT_W-1:0] ones_rd_q;
  logic [CNT_W-1:0] vcnt_q;
  logic [CNT_W-1:0] ones_rd_d;

  assign ones_rd_d = ones_rd_q + CNT_W'(ccff_tail);
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
`endif

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q      <= S_IDLE;
      word_ready_q <= 1'b0;
      ce_q         <= 1'b0;
      head_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      bit_count_q  <= '0;
      bits_left_q  <= '0;
`ifdef CCFF_LOADER_READBACK_CHECK_EN
      ones_ref_q   <= '0;
      ones_rd_q    <= '0;
      vcnt_q       <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q      <= S_FETCH;
            word_ready_q <= 1'b1;
            busy_q       <= 1'b1;
            bit_count_q  <= '0;
            err_q        <= 1'b0;
`ifdef CCFF_LOADER_READBACK_CHECK_EN
            ones_ref_q   <= '0;
            ones_rd_q    <= '0;
`endif
          end
        end
        S_FETCH: begin
          if (word_valid) begin
            state_q      <= S_SHIFT;
            word_ready_q <= 1'b0;
            ce_q         <= 1'b1;
            head_q       <= word_in[0];
            shreg_q      <= word_in >> 1;
            bits_left_q  <= take_d;
          end
        end
        S_SHIFT: begin
          head_q      <= shreg_q[0];
          shreg_q     <= shreg_q >> 1;
          bit_count_q <= bit_count_d;
          bits_left_q <= bits_left_q - ONE_C;
`ifdef CCFF_LOADER_READBACK_CHECK_EN
          ones_ref_q  <= ones_ref_q + CNT_W'(head_q);
`endif
          if (bits_left_q == ONE_C) begin
            head_q <= 1'b0;
            if (bit_count_d == LEN_C) begin
`ifdef CCFF_LOADER_READBACK_CHECK_EN
              // Enable stays high: the chain rotates through itself once more.
              state_q <= S_VERIFY;
              vcnt_q  <= '0;
`else
              state_q <= S_DONE;
              ce_q    <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              state_q      <= S_FETCH;
              ce_q         <= 1'b0;
              word_ready_q <= 1'b1;
            end
          end
        end
`ifdef CCFF_LOADER_READBACK_CHECK_EN
        S_VERIFY: begin
          vcnt_q    <= vcnt_q + ONE_C;
          ones_rd_q <= ones_rd_d;
          if (vcnt_q == LEN_C - ONE_C) begin
            state_q <= S_DONE;
            ce_q    <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= (ones_rd_d != ones_ref_q);
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign word_ready    = word_ready_q;
  assign config_enable = ce_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign bit_count     = bit_count_q;
  assign err           = err_q;
`ifdef CCFF_LOADER_READBACK_CHECK_EN
  assign ccff_head     = (state_q == S_VERIFY) ? ccff_tail : head_q;
`else
  assign ccff_head     = head_q;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench for ccff_chain_loader: a 20-cell/8-bit instance and a 16-cell/8-bit instance.
module tb_ccff_chain_loader;

  localparam int LA = 20;
  localparam int LB = 16;
`ifdef CCFF_LOADER_READBACK_CHECK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif
  localparam int CE_A  = LA * (1 + RB);
  localparam int LAT_A = 23 + RB * LA;
  localparam int CE_B  = LB * (1 + RB);
  localparam int LAT_B = 18 + RB * LB;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, wv = 1'b0;
  logic [7:0]  win = '0;
  logic        rdy, head, tail, ce, busy, done, err;
  logic [15:0] bc;
  logic [LA-1:0] chain_a = '0;
  logic        inject = 1'b0;

  logic        start_b = 1'b0, wv_b = 1'b0;
  logic [7:0]  win_b = '0;
  logic        rdy_b, head_b, tail_b, ce_b, busy_b, done_b, err_b;
  logic [15:0] bc_b;
  logic [LB-1:0] chain_b = '0;

  assign tail   = chain_a[LA-1] ^ inject;
  assign tail_b = chain_b[LB-1];

  ccff_chain_loader #(.CHAIN_LEN(LA), .WORD_W(8), .CNT_W(16)) dut_a (
    .prog_clk(clk), .pReset(rst), .start(start), .word_in(win), .word_valid(wv),
    .word_ready(rdy), .ccff_head(head), .ccff_tail(tail), .config_enable(ce),
    .busy(busy), .done(done), .bit_count(bc), .err(err));

  ccff_chain_loader #(.CHAIN_LEN(LB), .WORD_W(8), .CNT_W(16)) dut_b (
    .prog_clk(clk), .pReset(rst), .start(start_b), .word_in(win_b), .word_valid(wv_b),
    .word_ready(rdy_b), .ccff_head(head_b), .ccff_tail(tail_b), .config_enable(ce_b),
    .busy(busy_b), .done(done_b), .bit_count(bc_b), .err(err_b));

  // Chain models plus edge monitors.
  int cyc = 0, ce_cnt = 0, done_cnt = 0, ce_cnt_b = 0, done_cnt_b = 0, acc_b = 0;
  logic [63:0] hseq = '0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ce) begin
      chain_a <= {chain_a[LA-2:0], head};
      ce_cnt  <= ce_cnt + 1;
      hseq    <= {hseq[62:0], head};
    end
    if (done) done_cnt <= done_cnt + 1;
    if (ce_b) begin
      chain_b  <= {chain_b[LB-2:0], head_b};
      ce_cnt_b <= ce_cnt_b + 1;
    end
    if (done_b) done_cnt_b <= done_cnt_b + 1;
    if (rdy_b && wv_b) acc_b <= acc_b + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_mon();
    @(negedge clk);
    ce_cnt = 0; done_cnt = 0; hseq = '0;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic feed(input logic [7:0] w0, input logic [7:0] w1, input logic [7:0] w2,
                      input int n, output bit ok);
    int  idx;
    bit  acc;
    idx = 0; ok = 1'b0; win = w0; wv = 1'b1;
    for (int k = 0; k < 200; k++) begin
      acc = rdy;
      step();
      if (acc) begin
        idx++;
        if (idx == n) begin ok = 1'b1; break; end
        win = (idx == 1) ? w1 : w2;
      end
    end
    wv = 1'b0;
  endtask

  task automatic wait_done(output int t, output bit ok);
    ok = 1'b0; t = 0;
    for (int k = 0; k < 200; k++) begin
      if (done) begin ok = 1'b1; t = cyc; break; end
      step();
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (rdy) begin ok = 1'b1; break; end
      step();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; step(); step();
    n_chk++;
    if ({rdy, ce, head, busy, done, err, bc} !== 22'd0) begin
      n_fail++; $display("FAIL reset_a: outputs %b, required all 0", {rdy, ce, head, busy, done, err, bc});
    end
    n_chk++;
    if ({rdy_b, ce_b, head_b, busy_b, done_b, err_b, bc_b} !== 22'd0) begin
      n_fail++; $display("FAIL reset_b: outputs %b, required all 0", {rdy_b, ce_b, head_b, busy_b, done_b, err_b, bc_b});
    end
    rst = 1'b0; step();
  endtask

  task automatic test_full_load();
    bit ok1, ok2; int t0, t1;
    clear_mon();
    pulse_start(); t0 = cyc;
    n_chk++;
    if ({rdy, busy, ce} !== 3'b110) begin
      n_fail++; $display("FAIL fetch_entry: rdy/busy/ce %b, required 110", {rdy, busy, ce});
    end
    feed(8'hA5, 8'h3C, 8'hF7, 3, ok1);
    wait_done(t1, ok2);
    n_chk++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL full_timeout: feed %0d done %0d, required 1 1", ok1, ok2); end
    n_chk++;
    if (t1 - t0 !== LAT_A) begin n_fail++; $display("FAIL full_latency: %0d cycles, required %0d", t1 - t0, LAT_A); end
    n_chk++;
    if (bc !== 16'd20) begin n_fail++; $display("FAIL full_bitcount: %0d, required 20", bc); end
    n_chk++;
    if (hseq[19:0] !== 20'hA53CE && RB == 0) begin
      n_fail++; $display("FAIL full_head_seq: %h, required a53ce", hseq[19:0]);
    end
    step(); step(); step();
    n_chk++;
    if (ce_cnt !== CE_A) begin n_fail++; $display("FAIL full_ce_count: %0d, required %0d", ce_cnt, CE_A); end
    n_chk++;
    if (chain_a !== 20'hA53CE) begin n_fail++; $display("FAIL full_chain: %h, required a53ce", chain_a); end
    n_chk++;
    if ({done_cnt, busy, bc, err} !== {32'd1, 1'b0, 16'd20, 1'b0}) begin
      n_fail++; $display("FAIL full_after: done_cnt %0d busy %0d bc %0d err %0d, required 1 0 20 0", done_cnt, busy, bc, err);
    end
  endtask

  task automatic test_stall();
    bit ok1, ok2, ok3; int t;
    chain_a = '0;
    clear_mon();
    pulse_start();
    feed(8'hA5, 8'h00, 8'h00, 1, ok1);
    wait_ready(ok2);
    n_chk++;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL stall_reach: feed %0d ready %0d, required 1 1", ok1, ok2); end
    for (int i = 0; i < 7; i++) begin
      n_chk++;
      if ({ce, rdy, bc} !== {1'b0, 1'b1, 16'd8}) begin
        n_fail++; $display("FAIL stall_hold%0d: ce %0d rdy %0d bc %0d, required 0 1 8", i, ce, rdy, bc);
      end
      step();
    end
    n_chk++;
    if (ce_cnt !== 8) begin n_fail++; $display("FAIL stall_ce: %0d, required 8", ce_cnt); end
    feed(8'h3C, 8'hF7, 8'h00, 2, ok1);
    wait_done(t, ok3);
    step(); step();
    n_chk++;
    if ({ok1, ok3, bc} !== {1'b1, 1'b1, 16'd20} || chain_a !== 20'hA53CE) begin
      n_fail++; $display("FAIL stall_resume: ok %0d%0d bc %0d chain %h, required 11 20 a53ce", ok1, ok3, bc, chain_a);
    end
  endtask

  task automatic test_ignored_inputs();
    bit ok1, ok2, ok3; int t;
    chain_a = '0;
    clear_mon();
    pulse_start();
    feed(8'hA5, 8'h00, 8'h00, 1, ok1);
    step(); step();
    start = 1'b1; wv = 1'b1; win = 8'hFF;
    n_chk++;
    if ({rdy, ce} !== 2'b01) begin n_fail++; $display("FAIL ign_rdy: rdy %0d ce %0d, required 0 1", rdy, ce); end
    step();
    n_chk++;
    if ({rdy, busy, bc} !== {1'b0, 1'b1, 16'd3}) begin
      n_fail++; $display("FAIL ign_mid: rdy %0d busy %0d bc %0d, required 0 1 3", rdy, busy, bc);
    end
    step();
    start = 1'b0; wv = 1'b0;
    n_chk++;
    if (bc !== 16'd4) begin n_fail++; $display("FAIL ign_bitcount: %0d, required 4", bc); end
    wait_ready(ok2);
    feed(8'h3C, 8'hF7, 8'h00, 2, ok3);
    wait_done(t, ok3);
    step(); step();
    n_chk++;
    if ({ok1, ok2, ok3} !== 3'b111 || chain_a !== 20'hA53CE || ce_cnt !== CE_A) begin
      n_fail++; $display("FAIL ign_result: ok %b chain %h ce %0d, required 111 a53ce %0d", {ok1, ok2, ok3}, chain_a, ce_cnt, CE_A);
    end
  endtask

  task automatic test_reset_mid_load();
    bit ok1, ok2; int t, ce_snap;
    clear_mon();
    pulse_start();
    feed(8'hA5, 8'h00, 8'h00, 1, ok1);
    repeat (5) step();
    n_chk++;
    if (bc !== 16'd5) begin n_fail++; $display("FAIL rml_pre: bc %0d, required 5", bc); end
    rst = 1'b1; step(); rst = 1'b0;
    n_chk++;
    if ({rdy, ce, head, busy, done, err, bc} !== 22'd0) begin
      n_fail++; $display("FAIL rml_outputs: %b, required all 0", {rdy, ce, head, busy, done, err, bc});
    end
    ce_snap = ce_cnt;
    repeat (6) step();
    n_chk++;
    if (ce_cnt !== ce_snap || busy !== 1'b0) begin
      n_fail++; $display("FAIL rml_idle: ce %0d busy %0d, required %0d 0", ce_cnt, busy, ce_snap);
    end
    pulse_start();
    feed(8'hA5, 8'h3C, 8'hF7, 3, ok1);
    wait_done(t, ok2);
    step(); step();
    n_chk++;
    if ({ok1, ok2} !== 2'b11 || bc !== 16'd20 || chain_a !== 20'hA53CE) begin
      n_fail++; $display("FAIL rml_reload: ok %b bc %0d chain %h, required 11 20 a53ce", {ok1, ok2}, bc, chain_a);
    end
  endtask

  task automatic test_exact_multiple();
    int t0, t1, acc_after;
    bit got;
    start_b = 1'b1; step(); start_b = 1'b0; t0 = cyc;
    wv_b = 1'b1; win_b = 8'hA5;
    got = 1'b0; t1 = 0; acc_after = 0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (acc_b == 1) win_b = 8'h3C;
      if (acc_b >= 2) win_b = 8'h77;
      if (acc_b >= 2 && rdy_b) acc_after++;
      if (done_b && !got) begin got = 1'b1; t1 = cyc; end
      if (got && k > 45) break;
    end
    wv_b = 1'b0;
    n_chk++;
    if (!got || t1 - t0 !== LAT_B) begin
      n_fail++; $display("FAIL exact_latency: done %0d after %0d, required 1 after %0d", got, t1 - t0, LAT_B);
    end
    n_chk++;
    if (acc_b !== 2 || acc_after !== 0) begin
      n_fail++; $display("FAIL exact_fetch: accepted %0d extra-ready %0d, required 2 0", acc_b, acc_after);
    end
    n_chk++;
    if (ce_cnt_b !== CE_B || chain_b !== 16'hA53C || bc_b !== 16'd16 || done_cnt_b !== 1) begin
      n_fail++; $display("FAIL exact_result: ce %0d chain %h bc %0d done %0d, required %0d a53c 16 1", ce_cnt_b, chain_b, bc_b, done_cnt_b, CE_B);
    end
  endtask

`ifdef CCFF_LOADER_READBACK_CHECK_EN
  task automatic test_readback();
    bit ok1, ok2; int t;
    chain_a = '0;
    clear_mon();
    pulse_start();
    feed(8'hA5, 8'h3C, 8'hF7, 3, ok1);
    wait_done(t, ok2);
    n_chk++;
    if ({ok1, ok2, err} !== 3'b110 || chain_a !== 20'hA53CE) begin
      n_fail++; $display("FAIL rb_clean: ok %b err %0d chain %h, required 11 0 a53ce", {ok1, ok2}, err, chain_a);
    end
    clear_mon();
    pulse_start();
    feed(8'hA5, 8'h3C, 8'hF7, 3, ok1);
    for (int k = 0; k < 100 && ce_cnt < 25; k++) step();
    inject = 1'b1; step(); inject = 1'b0;
    wait_done(t, ok2);
    step();
    n_chk++;
    if ({ok1, ok2, err} !== 3'b111) begin
      n_fail++; $display("FAIL rb_fault: ok %b err %0d, required 11 1", {ok1, ok2}, err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full_load();
    test_stall();
    test_ignored_inputs();
    test_reset_mid_load();
    test_exact_multiple();
`ifdef CCFF_LOADER_READBACK_CHECK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
